// File: rtl/wb_lsu_pkg.sv
// Shared constants for the Wishbone load/store unit: funct3 codes, FSM states, lane masks.
// No logic of its own; the legality helper is a pure function.
// Imported by wb_lsu and wb_lsu_align.
package wb_lsu_pkg;

    // RV32 load/store width and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access width is carried in funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte-lane masks
    localparam logic [3:0] SEL_BYTE    = 4'b0001;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUS  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Stores only have signed-agnostic codes; loads add the unsigned byte/half forms
    function automatic logic f3_legal(input logic store, input logic [2:0] f3);
        logic common;
        common = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return store ? common : (common || (f3 == F3_BU) || (f3 == F3_HU));
    endfunction

endpackage

// File: rtl/wb_lsu_align.sv
// Lane/alignment datapath: byte-lane select, store replication, load shift+extend, request checks.
// Purely combinational, zero latency.
// No flow control; the parent FSM decides when outputs are used.
module wb_lsu_align
    import wb_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] bus_dat_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted;

    // Lane mask and replicated store data for the incoming request
    always_comb begin
        sel_o   = 4'b0000;
        wdata_o = wdata_i;
        unique case (funct3_i[1:0])
            SZ_BYTE: begin
                sel_o   = SEL_BYTE << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o   = addr_lo_i[1] ? SEL_HALF_HI : SEL_HALF_LO;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                sel_o   = SEL_WORD;
                wdata_o = wdata_i;
            end
            default: begin
                sel_o   = 4'b0000;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Request checks; misaligned is only meaningful for legal codes, the parent masks it
    always_comb begin
        illegal_o    = !f3_legal(store_i, funct3_i);
        misaligned_o = ((funct3_i[1:0] == SZ_HALF) && addr_lo_i[0]) ||
                       ((funct3_i[1:0] == SZ_WORD) && (addr_lo_i != 2'b00));
    end

    // Load data: bring the addressed lane down to bit 0, then extend to 32 bits
    always_comb begin
        shifted   = bus_dat_i >> {ld_addr_lo_i, 3'b000};
        ld_data_o = shifted;
        unique case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    ld_data_o = shifted;
            F3_BU:   ld_data_o = {24'd0, shifted[7:0]};
            F3_HU:   ld_data_o = {16'd0, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/wb_lsu.sv
// RV32 load/store unit driving one classic Wishbone cycle per core request.
// Latency: rejected requests done 1 cycle after accept; bus requests done 1 cycle after ack/err/timeout.
// Requests are only accepted while idle (busy_o=0); anything presented while busy is dropped.
module wb_lsu
    import wb_lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 17,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 store_i,
    input  logic [2:0]           funct3_i,
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      wdata_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [XLEN-1:0]      rdata_o,
    output logic                 misaligned_o,
    output logic                 fault_o,
    output logic [XLEN-1:0]      master_dat_o,
    input  logic [XLEN-1:0]      master_dat_i,
    output logic [ADDR_BITS-3:0] adr_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic [3:0]           sel_o,
    output logic                 we_o,
    input  logic                 ack_i,
    input  logic                 err_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t state_q, state_d;

    logic                 store_q;
    logic [2:0]           f3_q;
    logic [1:0]           alo_q;
    logic [ADDR_BITS-3:0] adr_q;
    logic [3:0]           sel_q;
    logic                 we_q;
    logic [XLEN-1:0]      dat_q;
    logic [XLEN-1:0]      rdata_q;
    logic                 mis_q;
    logic                 fault_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [3:0]      req_sel;
    logic [31:0]     req_wdat;
    logic            req_mis;
    logic            req_ill;
    logic [31:0]     ld_ext;
    logic            out_of_range;
    logic            req_fault;
    logic            req_reject;
    logic            accept;
    logic            timed_out;

    wb_lsu_align u_align (
        .funct3_i     (funct3_i),
        .store_i      (store_i),
        .addr_lo_i    (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .sel_o        (req_sel),
        .wdata_o      (req_wdat),
        .misaligned_o (req_mis),
        .illegal_o    (req_ill),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (alo_q),
        .bus_dat_i    (master_dat_i),
        .ld_data_o    (ld_ext)
    );

    assign out_of_range = |addr_i[XLEN-1:ADDR_BITS];
    assign req_fault    = req_ill || out_of_range;
    assign req_reject   = req_fault || req_mis;
    assign accept       = (state_q == S_IDLE) && req_i;
    assign timed_out    = (cnt_q == CNT_MAX);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: rejected requests skip the bus; any response or timeout ends the bus cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (req_i) state_d = req_reject ? S_DONE : S_BUS;
            S_BUS:   if (err_i || ack_i || timed_out) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
        cyc_o  = (state_q == S_BUS);
        stb_o  = (state_q == S_BUS);
    end

    // Request capture, bus-response capture and status flags
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            alo_q   <= 2'b00;
            adr_q   <= '0;
            sel_q   <= 4'b0000;
            we_q    <= 1'b0;
            dat_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        store_q <= store_i;
                        f3_q    <= funct3_i;
                        alo_q   <= addr_i[1:0];
                        adr_q   <= addr_i[ADDR_BITS-1:2];
                        sel_q   <= req_sel;
                        we_q    <= store_i;
                        dat_q   <= req_wdat;
                        // An illegal or out-of-range request reports fault only
                        fault_q <= req_fault;
                        mis_q   <= req_mis && !req_fault;
                    end
                end
                S_BUS: begin
                    // err_i beats ack_i and leaves the load result untouched
                    if (err_i) begin
                        fault_q <= 1'b1;
                    end else if (ack_i) begin
                        if (!store_q) rdata_q <= ld_ext;
                    end else if (timed_out) begin
                        fault_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    fault_q <= 1'b0;
                    mis_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Timeout counter: zeroed on bus entry, counts bus cycles without a response
    always_ff @(posedge clk_i) begin
        if (!rst_i)                 cnt_q <= '0;
        else if (accept)            cnt_q <= '0;
        else if (state_q == S_BUS)  cnt_q <= cnt_q + 1'b1;
    end

    assign adr_o        = adr_q;
    assign sel_o        = sel_q;
    assign we_o         = we_q;
    assign master_dat_o = dat_q;
    assign rdata_o      = rdata_q;
    assign misaligned_o = mis_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Self-checking bench for wb_lsu: directed cases plus randomized load/store traffic.
// Expected values come from an arithmetic model of the access rules kept in this file.
module tb_wb_lsu;

    localparam int TMO = 15;
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_i = 1'b0;
    logic        store_i = 1'b0;
    logic [2:0]  funct3_i = 3'd0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic        busy_o, done_o, misaligned_o, fault_o;
    logic [31:0] rdata_o, master_dat_o;
    logic [31:0] master_dat_i = 32'd0;
    logic [14:0] adr_o;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_rdata = 32'd0;

    wb_lsu #(.XLEN(32), .ADDR_BITS(17), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .store_i(store_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .misaligned_o(misaligned_o), .fault_o(fault_o),
        .master_dat_o(master_dat_o), .master_dat_i(master_dat_i),
        .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o),
        .we_o(we_o), .ack_i(ack_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---- reference model: access rules as plain arithmetic ----
    function automatic int unsigned acc_size(input logic [2:0] f3);
        int unsigned w;
        w = f3 % 4;
        return (w == 0) ? 1 : (w == 1) ? 2 : 4;
    endfunction

    function automatic bit m_legal(input bit st, input logic [2:0] f3);
        if (st) return f3 <= 2;
        return (f3 <= 2) || (f3 == 4) || (f3 == 5);
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
        int unsigned off, sz;
        off = a % 4;
        sz  = acc_size(f3);
        if (sz == 1) return 4'(2 ** off);
        if (sz == 2) return (off >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdat(input logic [2:0] f3, input logic [31:0] d);
        int unsigned sz;
        sz = acc_size(f3);
        if (sz == 1) return (d % 256) * 32'h0101_0101;
        if (sz == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] bus);
        longint unsigned v;
        int unsigned off;
        off = a % 4;
        v = longint'(bus) / (64'd1 << (8 * off));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v + 64'hFFFF_FF00; end
            3'd1: begin v = v % 65536; if (v >= 32768) v = v + 64'hFFFF_0000; end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = v % (64'd1 << 32);
        endcase
        return v[31:0];
    endfunction

    // One full transaction from an idle DUT; called at posedge+1
    task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] bus,
                          input int mode, input int wt, input bit pulse);
        bit legal, oor, mis, reject;
        int n, exp_n;
        legal  = m_legal(st, f3);
        oor    = (a >= 32'h0002_0000);
        mis    = legal && ((a % acc_size(f3)) != 0);
        reject = !legal || oor || mis;

        store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
        master_dat_i = bus;
        @(posedge clk_i); #1;
        req_i = 1'b0;

        if (reject) begin
            check("rej_cyc", {31'd0, cyc_o}, 32'd0);
            check("rej_done", {31'd0, done_o}, 32'd1);
            check("rej_fault", {31'd0, fault_o}, {31'd0, !legal || oor});
            check("rej_mis", {31'd0, misaligned_o}, {31'd0, mis && !oor});
            check("rej_rdata", rdata_o, exp_rdata);
        end else begin
            n = 0;
            while (cyc_o === 1'b1 && n < 40) begin
                if (n == 0) begin
                    check("sel", {28'd0, sel_o}, {28'd0, m_sel(f3, a)});
                    check("adr", {17'd0, adr_o}, a / 4);
                    check("we", {31'd0, we_o}, {31'd0, st});
                    if (st) check("wdat", master_dat_o, m_wdat(f3, wd));
                    if (pulse) begin
                        req_i = 1'b1; store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h40;
                    end
                end
                if (mode != M_NONE && n == wt) begin
                    ack_i = (mode == M_ACK) || (mode == M_BOTH);
                    err_i = (mode == M_ERR) || (mode == M_BOTH);
                end
                @(posedge clk_i); #1;
                ack_i = 1'b0; err_i = 1'b0; req_i = 1'b0;
                n++;
            end
            exp_n = (mode == M_NONE) ? TMO + 1 : wt + 1;
            check("bus_cycles", n, exp_n);
            if (mode == M_ACK && !st) exp_rdata = m_load(f3, a, bus);
            check("done", {31'd0, done_o}, 32'd1);
            check("fault", {31'd0, fault_o}, {31'd0, mode != M_ACK});
            check("mis", {31'd0, misaligned_o}, 32'd0);
            check("rdata", rdata_o, exp_rdata);
        end
        @(posedge clk_i); #1;
        check("done_pulse", {31'd0, done_o}, 32'd0);
        check("idle", {30'd0, busy_o, cyc_o}, 32'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_bus", {28'd0, cyc_o, stb_o, we_o, |sel_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_mdat", master_dat_o, 32'd0);
        check("rst_adr", {17'd0, adr_o}, 32'd0);
        check("rst_flags", {30'd0, fault_o, misaligned_o}, 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // directed cases
        do_txn(1'b0, 3'd2, 32'h0100, 32'd0, 32'hDEADBEEF, M_ACK, 2, 1'b0);
        check("lw_result", rdata_o, 32'hDEADBEEF);
        do_txn(1'b0, 3'd0, 32'h0103, 32'd0, 32'h80123456, M_ACK, 0, 1'b0);
        check("lb_result", rdata_o, 32'hFFFFFF80);
        do_txn(1'b0, 3'd4, 32'h0103, 32'd0, 32'h80123456, M_ACK, 1, 1'b0);
        check("lbu_result", rdata_o, 32'h00000080);
        do_txn(1'b1, 3'd1, 32'h0202, 32'h0000ABCD, 32'h11111111, M_ACK, 0, 1'b0);
        do_txn(1'b0, 3'd2, 32'h0102, 32'd0, 32'h0, M_ACK, 0, 1'b0);
        do_txn(1'b0, 3'd3, 32'h0100, 32'd0, 32'h0, M_ACK, 0, 1'b0);
        do_txn(1'b1, 3'd4, 32'h0101, 32'd0, 32'h0, M_ACK, 0, 1'b0);
        do_txn(1'b0, 3'd2, 32'h0002_0000, 32'd0, 32'h0, M_ACK, 0, 1'b0);
        do_txn(1'b0, 3'd2, 32'h0300, 32'd0, 32'h12345678, M_NONE, 0, 1'b0);
        do_txn(1'b0, 3'd2, 32'h0300, 32'd0, 32'h12345678, M_BOTH, 1, 1'b0);
        do_txn(1'b0, 3'd5, 32'h0302, 32'd0, 32'hCAFE0000, M_ERR, 3, 1'b0);
        do_txn(1'b0, 3'd1, 32'h0306, 32'd0, 32'h8001_7FFF, M_ACK, 1, 1'b1);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int r, mode;
            a = $urandom & 32'h0001_FFFF;
            if ($urandom_range(0, 15) == 0) a = a | ($urandom << 17);
            r = $urandom_range(0, 19);
            mode = (r < 15) ? M_ACK : (r < 17) ? M_ERR : (r < 19) ? M_BOTH : M_NONE;
            do_txn($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom, mode, $urandom_range(0, 4), $urandom_range(0, 7) == 0);
        end

        // reset during a bus cycle
        store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h0400; req_i = 1'b1;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_cyc_before", {31'd0, cyc_o}, 32'd1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("mid_rst_cyc", {30'd0, cyc_o, stb_o}, 32'd0);
        check("mid_rst_done", {31'd0, done_o}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check("mid_rst_regs", {17'd0, adr_o} | {28'd0, sel_o} | master_dat_o | rdata_o, 32'd0);
        rst_i = 1'b1;
        exp_rdata = 32'd0;
        @(posedge clk_i); #1;
        check("post_rst_done", {31'd0, done_o}, 32'd0);
        do_txn(1'b0, 3'd2, 32'h0100, 32'd0, 32'h0BADF00D, M_ACK, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
